// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port and shared memory bus as seen by the arbiter
interface mem_bus_arbiter_if;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_stallreq_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_data_i;
  logic [31:0] data_data_o;
  logic        data_stallreq_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  modport master (
    input  inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i, data_sel_i, data_data_i,
    input  bus_data_i, bus_ack_i,
    output inst_data_o, inst_stallreq_o, data_data_o, data_stallreq_o,
    output bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o
  );
  modport slave (
    output inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_addr_i, data_sel_i, data_data_i,
    output bus_data_i, bus_ack_i,
    input  inst_data_o, inst_stallreq_o, data_data_o, data_stallreq_o,
    input  bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o, bus_err_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one ack-based memory bus between fetch and data ports
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master mb
);
  typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
  state_t      state, state_nx;
  logic        last_d, pick_d, pick_i, gnt, timeout, done;
  logic        we_q, err_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q, wdata_q, inst_q, data_q;
  logic [15:0] cnt;
  always_comb begin
    pick_d = mb.data_ce_i & (~mb.inst_ce_i | ~last_d);
    pick_i = mb.inst_ce_i & ~pick_d;
    gnt = (state == GNT_I) | (state == GNT_D);
    timeout = gnt & ~mb.bus_ack_i & (cnt == LAST_WAIT);
    done = mb.bus_ack_i | timeout;
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = pick_d ? GNT_D : pick_i ? GNT_I : IDLE;
      GNT_I:   state_nx = done ? DONE_I : GNT_I;
      GNT_D:   state_nx = done ? DONE_D : GNT_D;
      default: state_nx = IDLE;
    endcase
  end
  assign mb.bus_ce_o = gnt;
  assign mb.bus_we_o = gnt & we_q;
  assign mb.bus_addr_o = gnt ? addr_q : '0;
  assign mb.bus_sel_o = gnt ? sel_q : '0;
  assign mb.bus_data_o = gnt ? wdata_q : '0;
  assign mb.bus_err_o = err_q;
  assign mb.inst_data_o = inst_q;
  assign mb.data_data_o = data_q;
  assign mb.inst_stallreq_o = mb.inst_ce_i & (state != DONE_I);
  assign mb.data_stallreq_o = mb.data_ce_i & (state != DONE_D);
  // the request is frozen at grant so requester changes mid-transaction never reach the bus
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last_d <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      err_q <= 1'b0;
      inst_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      err_q <= timeout;
      if (state == IDLE && state_nx != IDLE) begin
        last_d <= pick_d;
        we_q <= pick_d & mb.data_we_i;
        sel_q <= pick_d ? mb.data_sel_i : 4'hF;
        addr_q <= pick_d ? mb.data_addr_i : mb.inst_addr_i;
        wdata_q <= pick_d ? mb.data_data_i : '0;
        cnt <= '0;
      end else if (gnt && !mb.bus_ack_i)
        cnt <= cnt + 16'd1;
      if (state == GNT_I && done)
        inst_q <= timeout ? '0 : mb.bus_data_i;
      if (state == GNT_D && (timeout || (mb.bus_ack_i && !we_q)))
        data_q <= timeout ? '0 : mb.bus_data_i;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized requests against a transaction-level model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_bus_arbiter_if mb();
  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .mb(mb));
  always #5 clk = ~clk;
  int n_asrt = 0;
  int n_fail = 0;
  int plan = 0;
  int wcnt = 0;
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] exp_id, exp_dd;
  logic        ic, dc, dwe, to, first_d, last_was_d, pend_i, pend_d;
  logic [31:0] ia, da, dw;
  logic [3:0]  ds;
  int          pl, g, done_i, done_d, exp_done_i, exp_done_d;
  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction
  function automatic logic [31:0] resp_rd(logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : a ^ 32'h9E37_79B9;
  endfunction
  function automatic logic [31:0] model_rd(logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : a ^ 32'h9E37_79B9;
  endfunction
  // memory-side responder: acks after 'plan' wait states, never when plan < 0
  always @(posedge clk) begin
    #1;
    if (mb.bus_ce_o) begin
      mb.bus_ack_i = (plan >= 0) && (wcnt == plan);
      mb.bus_data_i = resp_rd(mb.bus_addr_o);
      if (mb.bus_ack_i && mb.bus_we_o)
        resp_mem[mb.bus_addr_o] = merge(resp_rd(mb.bus_addr_o), mb.bus_data_o, mb.bus_sel_o);
      wcnt++;
    end else begin
      mb.bus_ack_i = 1'b0;
      mb.bus_data_i = 32'hDEAD_BEEF;
      wcnt = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    mb.inst_ce_i = 1'b0;
    mb.data_ce_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask
  initial begin
    mb.inst_ce_i = 1'b0; mb.inst_addr_i = '0;
    mb.data_ce_i = 1'b0; mb.data_we_i = 1'b0; mb.data_addr_i = '0;
    mb.data_sel_i = 4'hF; mb.data_data_i = '0;
    resp_mem[32'h10] = 32'h3C01_0001;
    model_mem[32'h10] = 32'h3C01_0001;
    repeat (2) tick();
    chk("rst_bus_ce", mb.bus_ce_o, 0);
    chk("rst_bus_addr", mb.bus_addr_o, 0);
    chk("rst_inst_data", mb.inst_data_o, 0);
    chk("rst_data_data", mb.data_data_o, 0);
    chk("rst_err", mb.bus_err_o, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    // single zero-wait fetch
    plan = 0;
    mb.inst_ce_i = 1'b1; mb.inst_addr_i = 32'h10;
    #1;
    chk("f_stall_c0", mb.inst_stallreq_o, 1);
    tick();
    chk("f_bus_ce", mb.bus_ce_o, 1);
    chk("f_bus_addr", mb.bus_addr_o, 32'h10);
    chk("f_bus_sel", mb.bus_sel_o, 4'hF);
    chk("f_bus_we", mb.bus_we_o, 0);
    chk("f_stall_c1", mb.inst_stallreq_o, 1);
    tick();
    chk("f_data", mb.inst_data_o, 32'h3C01_0001);
    chk("f_stall_c2", mb.inst_stallreq_o, 0);
    chk("f_bus_ce_done", mb.bus_ce_o, 0);
    mb.inst_ce_i = 1'b0;
    tick();
    // simultaneous requests from reset: D, I, D, I
    do_reset();
    plan = 0;
    mb.inst_ce_i = 1'b1; mb.inst_addr_i = 32'h20;
    mb.data_ce_i = 1'b1; mb.data_we_i = 1'b0; mb.data_addr_i = 32'h100; mb.data_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_gnt_addr", mb.bus_addr_o, (k % 2 == 0) ? 32'h100 : 32'h20);
      chk("tie_stall_i_gnt", mb.inst_stallreq_o, 1);
      chk("tie_stall_d_gnt", mb.data_stallreq_o, 1);
      tick();
      if (k % 2 == 0) begin
        chk("tie_stall_d_done", mb.data_stallreq_o, 0);
        chk("tie_stall_i_wait", mb.inst_stallreq_o, 1);
        chk("tie_data_d", mb.data_data_o, model_rd(32'h100));
      end else begin
        chk("tie_stall_i_done", mb.inst_stallreq_o, 0);
        chk("tie_stall_d_wait", mb.data_stallreq_o, 1);
        chk("tie_data_i", mb.inst_data_o, model_rd(32'h20));
      end
      tick();
    end
    mb.inst_ce_i = 1'b0; mb.data_ce_i = 1'b0;
    exp_dd = model_rd(32'h100);
    tick();
    // data write with three wait states
    plan = 3;
    mb.data_ce_i = 1'b1; mb.data_we_i = 1'b1; mb.data_addr_i = 32'h104;
    mb.data_sel_i = 4'b0011; mb.data_data_i = 32'h0000_BEEF;
    model_mem[32'h104] = merge(model_rd(32'h104), 32'h0000_BEEF, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("w_bus_ce", mb.bus_ce_o, 1);
      chk("w_stall", mb.data_stallreq_o, 1);
      if (c == 1) begin
        chk("w_bus_addr", mb.bus_addr_o, 32'h104);
        chk("w_bus_we", mb.bus_we_o, 1);
        chk("w_bus_sel", mb.bus_sel_o, 4'b0011);
        chk("w_bus_wdata", mb.bus_data_o, 32'h0000_BEEF);
      end
    end
    tick();
    chk("w_stall_done", mb.data_stallreq_o, 0);
    chk("w_bus_ce_done", mb.bus_ce_o, 0);
    chk("w_data_held", mb.data_data_o, exp_dd);
    chk("w_no_err", mb.bus_err_o, 0);
    // read back the partially written word
    plan = 0;
    mb.data_we_i = 1'b0; mb.data_sel_i = 4'hF;
    tick();
    tick();
    tick();
    chk("rb_data", mb.data_data_o, model_rd(32'h104));
    mb.data_ce_i = 1'b0;
    tick();
    // timeout: ack never arrives
    plan = -1;
    mb.data_ce_i = 1'b1; mb.data_addr_i = 32'h108;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("to_bus_ce", mb.bus_ce_o, 1);
      chk("to_err_early", mb.bus_err_o, 0);
    end
    tick();
    chk("to_err", mb.bus_err_o, 1);
    chk("to_data_zero", mb.data_data_o, 0);
    chk("to_stall_done", mb.data_stallreq_o, 0);
    mb.data_ce_i = 1'b0;
    tick();
    chk("to_err_cleared", mb.bus_err_o, 0);
    chk("to_idle_bus_ce", mb.bus_ce_o, 0);
    // flush: fetch drops ce mid-transaction while a data read waits
    plan = 2;
    mb.inst_ce_i = 1'b1; mb.inst_addr_i = 32'h30;
    tick();
    mb.inst_ce_i = 1'b0;
    mb.data_ce_i = 1'b1; mb.data_addr_i = 32'h10C;
    #1;
    chk("fl_stall_i_c1", mb.inst_stallreq_o, 0);
    for (int c = 2; c <= 3; c++) begin
      tick();
      chk("fl_bus_ce", mb.bus_ce_o, 1);
      chk("fl_stall_i", mb.inst_stallreq_o, 0);
    end
    tick();
    chk("fl_done_bus_ce", mb.bus_ce_o, 0);
    chk("fl_inst_data", mb.inst_data_o, model_rd(32'h30));
    chk("fl_stall_d_wait", mb.data_stallreq_o, 1);
    tick();
    tick();
    chk("fl_d_gnt", mb.bus_ce_o, 1);
    chk("fl_d_addr", mb.bus_addr_o, 32'h10C);
    tick();
    tick();
    tick();
    chk("fl_d_data", mb.data_data_o, model_rd(32'h10C));
    mb.data_ce_i = 1'b0;
    tick();
    // reset in the middle of a stalled data transaction
    plan = -1;
    mb.data_ce_i = 1'b1; mb.data_addr_i = 32'h110;
    tick();
    mb.inst_ce_i = 1'b1; mb.inst_addr_i = 32'h40;
    chk("rm_gnt_d", mb.bus_ce_o, 1);
    tick();
    #2;
    rst = 1'b0;
    mb.data_ce_i = 1'b0;
    #1;
    chk("rm_bus_ce", mb.bus_ce_o, 0);
    chk("rm_data_data", mb.data_data_o, 0);
    chk("rm_inst_data", mb.inst_data_o, 0);
    chk("rm_stall_i", mb.inst_stallreq_o, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    plan = 0;
    tick();
    chk("rm_fetch_gnt", mb.bus_ce_o, 1);
    chk("rm_fetch_addr", mb.bus_addr_o, 32'h40);
    tick();
    chk("rm_fetch_data", mb.inst_data_o, model_rd(32'h40));
    mb.inst_ce_i = 1'b0;
    tick();
    // randomized requests against the transaction-level model
    do_reset();
    exp_id = '0;
    exp_dd = '0;
    last_was_d = 1'b0;
    for (int it = 0; it < 40; it++) begin
      ic = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      if (!ic && !dc) ic = 1'b1;
      ia = 32'h0000_1000 + 32'($urandom_range(0, 63)) * 4;
      da = 32'h0002_0000 + 32'($urandom_range(0, 15)) * 4;
      dwe = 1'($urandom_range(0, 1));
      ds = 4'($urandom_range(1, 15));
      dw = $urandom;
      pl = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      to = (pl < 0);
      g = to ? 4 : pl + 1;
      first_d = !ic ? 1'b1 : !dc ? 1'b0 : !last_was_d;
      exp_done_i = !ic ? -1 : (first_d ? 2 * g + 3 : g + 1);
      exp_done_d = !dc ? -1 : (first_d ? g + 1 : 2 * g + 3);
      last_was_d = (ic && dc) ? !first_d : first_d;
      if (ic) exp_id = to ? '0 : model_rd(ia);
      if (dc) begin
        if (to) exp_dd = '0;
        else if (dwe) model_mem[da] = merge(model_rd(da), dw, ds);
        else exp_dd = model_rd(da);
      end
      plan = pl;
      mb.inst_ce_i = ic; mb.inst_addr_i = ia;
      mb.data_ce_i = dc; mb.data_we_i = dwe; mb.data_addr_i = da;
      mb.data_sel_i = ds; mb.data_data_i = dw;
      pend_i = ic; pend_d = dc;
      done_i = -1; done_d = -1;
      for (int c = 1; c <= 2 * g + 6 && (pend_i || pend_d); c++) begin
        tick();
        if (c == 1) begin
          chk("rnd_gnt_addr", mb.bus_addr_o, first_d ? da : ia);
          chk("rnd_gnt_sel", mb.bus_sel_o, first_d ? ds : 4'hF);
          chk("rnd_gnt_we", mb.bus_we_o, first_d & dwe);
        end
        if (pend_i && !mb.inst_stallreq_o) begin
          done_i = c; pend_i = 1'b0; mb.inst_ce_i = 1'b0;
          chk("rnd_inst_data", mb.inst_data_o, exp_id);
          chk("rnd_inst_err", mb.bus_err_o, to);
        end
        if (pend_d && !mb.data_stallreq_o) begin
          done_d = c; pend_d = 1'b0; mb.data_ce_i = 1'b0;
          chk("rnd_data_data", mb.data_data_o, exp_dd);
          chk("rnd_data_err", mb.bus_err_o, to);
        end
      end
      chk("rnd_done_i_cycle", done_i, exp_done_i);
      chk("rnd_done_d_cycle", done_d, exp_done_d);
      tick();
      chk("rnd_idle_bus_ce", mb.bus_ce_o, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between the instruction-fetch port and the mem-stage data port. Each requester presents a request and holds it while its stall request is high. The arbiter serializes the two onto one ack-based bus, registers the returned data, and drops the matching stall request for exactly one cycle when the data is valid. It sits between the fetch/mem stages and the SRAM/bus interface, and its stall outputs feed the pipeline control block.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of bus cycles spent waiting for `bus_ack_i` before a transaction is forcibly ended. Legal range 1..65535.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_ce_i  in  1  fetch request.
- inst_addr_i  in  32  fetch byte address.
- inst_data_o  out  32  registered fetch data.
- inst_stallreq_o  out  1  fetch stall request.
- data_ce_i  in  1  data request.
- data_we_i  in  1  data write enable (1 = write).
- data_addr_i  in  32  data byte address.
- data_sel_i  in  4  data byte selects.
- data_data_i  in  32  write data.
- data_data_o  out  32  registered read data.
- data_stallreq_o  out  1  data stall request.
- bus_ce_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  bus address.
- bus_sel_o  out  4  bus byte selects.
- bus_data_o  out  32  bus write data.
- bus_data_i  in  32  bus read data.
- bus_ack_i  in  1  bus transfer complete; sampled only while `bus_ce_o` is 1.
- bus_err_o  out  1  one-cycle pulse on timeout.

## Operation
- **States.**
  - IDLE: no bus cycle in progress.
  - GNT_I: fetch transaction on the bus.
  - GNT_D: data transaction on the bus.
  - DONE_I: fetch result is valid.
  - DONE_D: data result is valid.
- **Arbitration in IDLE.**
  - Only one `ce_i` high: grant that port.
  - Both high: grant the port not in `last_gnt` (round-robin).
  - `last_gnt` resets to I, so data wins the first tie.
  - On entering GNT_x, set `last_gnt` to x.
  - On entering GNT_x, latch addr, we, sel and wdata into bus registers.
- **Fetch grant bus fields:** we = 0, sel = 4'b1111, wdata = 0.
- **Bus outputs while in GNT_x:** `bus_ce_o` = 1 and the bus fields come from the latched registers. In every other state all bus outputs are 0.
- **GNT_x exit:**
  - `bus_ack_i` = 1: capture `bus_data_i` into x's data_o (reads only; a write leaves `data_data_o` unchanged), then go to DONE_x.
  - Wait counter reaches TIMEOUT_CYCLES without ack: go to DONE_x, load 0 into x's data_o, pulse `bus_err_o`.
- **DONE_x:** always goes to IDLE next cycle.
- **Stall requests:**
  - `inst_stallreq_o` = `inst_ce_i` & (state != DONE_I).
  - `data_stallreq_o` = `data_ce_i` & (state != DONE_D).
  - Both are combinational from state and inputs.
- **Requester contract:**
  - Hold ce/addr/data stable while its stall is high.
  - The pipeline advances on the DONE edge, so the request seen in the following IDLE is a new one.
- **Requester drops ce during GNT_x (flush):** the bus transaction still completes, data is still captured, and the FSM still passes through DONE_x. No stall is asserted for the dropped port.
- **Inputs outside the latch:** requester input changes after the GNT_x latch have no effect on the bus.
- **Wait counter:**
  - 16 bits, cleared on entering GNT_x.
  - Increments each GNT cycle without ack.
  - Timeout fires when count == TIMEOUT_CYCLES - 1 and ack = 0.
  - Ack on that same cycle takes priority: normal completion, no error.

## Timing
- **Reset:** rst low asynchronously forces:
  - state IDLE and `last_gnt` = I;
  - all `bus_*` outputs 0;
  - `inst_data_o` and `data_data_o` = 0;
  - `bus_err_o` = 0 and counter = 0.
  - Any in-flight transaction is dropped. The first grant is possible on the first rising edge after release.
- **Zero-wait bus, single request:**
  - cycle 0: IDLE, request seen, stall high.
  - cycle 1: GNT with ack.
  - cycle 2: DONE, data_o valid, stall low.
  - The pipeline advances at the end of cycle 2. Total 3 cycles; each bus wait state adds 1.
- **Back-to-back different ports:** minimum 3 cycles per transaction (IDLE→GNT→DONE). No bus overlap.
- **Held outputs:** data_o holds its value until the next capture for that port.
- **Error pulse:** `bus_err_o` is registered and high only during the DONE_x cycle of a timed-out transaction.

## Test plan
- **Reset mid-transaction:** assert rst low in GNT_D with ack withheld → same cycle `bus_ce_o` = 0 and data_o = 0; after release a pending fetch is granted at the next IDLE.
- **Single fetch:** `inst_ce_i` = 1, addr 0x00000010; bus acks 1 cycle after ce with 0x3C010001 → `bus_addr_o` = 0x10, sel = 4'b1111 for 1 cycle; `inst_data_o` = 0x3C010001 and `inst_stallreq_o` = 0 in the next cycle.
- **Simultaneous requests from reset:** fetch 0x20 and data read 0x100 both pending → data granted first, then fetch. On a repeated tie the grant alternates D, I, D, I; the non-granted stall stays high throughout.
- **Data write:** we = 1, sel 4'b0011, addr 0x104, wdata 0x0000BEEF, 3 wait states → `bus_ce_o` held 4 cycles; `data_data_o` unchanged; stall low exactly once, 5 cycles after the request.
- **Timeout:** TIMEOUT_CYCLES = 4 and ack never asserted → `bus_ce_o` high 4 cycles; `bus_err_o` = 1 for 1 cycle with `data_data_o` = 0; FSM back in IDLE. In a separate run, ack on the 4th cycle → no error.
- **Flush:** `inst_ce_i` dropped during GNT_I → bus cycle completes; `inst_stallreq_o` stays 0; a pending data request is granted right after DONE_I.
